// File: rtl/fc_pkg.sv
// Shared sizes and state encoding for the FC memory, FC controller and
// FC burst writer, so all three agree on word width, depth and addressing.
package fc_pkg;

    localparam int FC_WORD_W    = 16;
    localparam int FC_NUM_WORDS = 120;
    localparam int FC_ADDR_W    = 14;
    // Enough bits to hold a word count of 0..FC_NUM_WORDS inclusive.
    localparam int FC_CNT_W     = $clog2(FC_NUM_WORDS + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FINISH = 2'd2
    } fc_state_t;

endpackage

// File: rtl/fc_burst_writer.sv
// Streams a latched FC result vector into the 16-bit FC memory, one word per
// cycle at consecutive (wrapping) addresses from a base, with a hold input
// that stalls the burst.
//
// Handshake: start is sampled only in IDLE; the accepting edge latches the
// operands and raises busy. busy stays high until the cycle in which done
// pulses for exactly one cycle; start seen while busy is dropped entirely.
module fc_burst_writer
    import fc_pkg::*;
#(
    parameter int WORD_W    = FC_WORD_W,
    parameter int NUM_WORDS = FC_NUM_WORDS,
    parameter int ADDR_W    = FC_ADDR_W,
    parameter int CNT_W     = FC_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [CNT_W-1:0]            count,
    input  logic [WORD_W*NUM_WORDS-1:0] vec_in,
    input  logic                        hold,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [WORD_W-1:0]           mem_data,
    output logic                        mem_write_enable,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  dbg_state
);

    fc_state_t                   r_state;
    fc_state_t                   w_state_nxt;

    // Latched operands. The vector shifts right one word per write, so the
    // word to send next is always in the low WORD_W bits.
    logic [WORD_W*NUM_WORDS-1:0] r_vec;
    logic [ADDR_W-1:0]           r_base;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            r_idx;

    logic [ADDR_W-1:0]           r_addr;
    logic [WORD_W-1:0]           r_data;
    logic                        r_we;
    logic                        r_busy;
    logic                        r_done;

    logic [CNT_W-1:0]            w_eff_cnt;
    logic                        w_last;
    logic                        w_accept;
    logic                        w_advance;
    logic [ADDR_W-1:0]           w_addr_nxt;
    logic [WORD_W-1:0]           w_data_nxt;
    logic                        w_we_nxt;
    logic                        w_busy_nxt;
    logic                        w_done_nxt;

    // Requests longer than the vector are clamped to the vector length.
    assign w_eff_cnt = (count > CNT_W'(NUM_WORDS)) ? CNT_W'(NUM_WORDS) : count;
    // Only meaningful in WRITE, where r_cnt is at least 1.
    assign w_last    = (r_idx == (r_cnt - CNT_W'(1)));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a zero-length burst skips straight to FINISH.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_eff_cnt != '0) ? ST_WRITE : ST_FINISH;
                end
            end
            ST_WRITE: begin
                if (!hold && w_last) begin
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Output and datapath control: values the output registers take next.
    always_comb begin
        w_accept   = 1'b0;
        w_advance  = 1'b0;
        w_addr_nxt = r_addr;
        w_data_nxt = r_data;
        w_we_nxt   = 1'b0;
        w_busy_nxt = r_busy;
        w_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept   = 1'b1;
                    w_busy_nxt = 1'b1;
                end
            end
            ST_WRITE: begin
                if (!hold) begin
                    w_advance  = 1'b1;
                    w_we_nxt   = 1'b1;
                    w_addr_nxt = r_base + ADDR_W'(r_idx);
                    w_data_nxt = r_vec[WORD_W-1:0];
                end
            end
            ST_FINISH: begin
                w_done_nxt = 1'b1;
                w_busy_nxt = 1'b0;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Operand latch, shift register and word index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec  <= '0;
            r_base <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_vec  <= vec_in;
            r_base <= base_addr;
            r_cnt  <= w_eff_cnt;
            r_idx  <= '0;
        end else if (w_advance) begin
            r_vec  <= r_vec >> WORD_W;
            r_idx  <= r_idx + CNT_W'(1);
        end
    end

    // Registered memory-side and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_data <= '0;
            r_we   <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_addr <= w_addr_nxt;
            r_data <= w_data_nxt;
            r_we   <= w_we_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign mem_address      = r_addr;
    assign mem_data         = r_data;
    assign mem_write_enable = r_we;
    assign busy             = r_busy;
    assign done             = r_done;
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_fc_burst_writer.sv
// Bench for fc_burst_writer: a stimulus table of bursts, hand-written
// sequences for back-to-back, ignored start and mid-burst reset, and a
// randomized phase, all checked against a queue of expected writes built
// from the burst rules (clamp, wrap, hold stalls).
module tb_fc_burst_writer;
  import fc_pkg::*;

  localparam int WORD_W    = FC_WORD_W;
  localparam int NUM_WORDS = FC_NUM_WORDS;
  localparam int ADDR_W    = FC_ADDR_W;
  localparam int CNT_W     = FC_CNT_W;
  localparam int HP_N      = 1024;
  localparam int EW        = 32 + ADDR_W + WORD_W;

  // ---------------- clock / reset ----------------
  logic                        clk;
  logic                        rst_n;
  logic                        start;
  logic [ADDR_W-1:0]           base_addr;
  logic [CNT_W-1:0]            count;
  logic [WORD_W*NUM_WORDS-1:0] vec_in;
  logic                        hold;
  logic [ADDR_W-1:0]           mem_address;
  logic [WORD_W-1:0]           mem_data;
  logic                        mem_write_enable;
  logic                        busy;
  logic                        done;
  logic [1:0]                  dbg_state;

  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  fc_burst_writer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .base_addr        (base_addr),
    .count            (count),
    .vec_in           (vec_in),
    .hold             (hold),
    .mem_address      (mem_address),
    .mem_data         (mem_data),
    .mem_write_enable (mem_write_enable),
    .busy             (busy),
    .done             (done),
    .dbg_state        (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]               exp_q[$];
  bit                          exp_done_at[int];
  int                          bz_lo = 0;
  int                          bz_hi = 0;
  int                          n_chk = 0;
  int                          n_err = 0;
  int                          n_wr  = 0;
  logic [ADDR_W-1:0]           last_wr_addr;
  logic [WORD_W-1:0]           mem_model [0:(1<<ADDR_W)-1];
  logic [WORD_W*NUM_WORDS-1:0] stim_vec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [WORD_W*NUM_WORDS-1:0] rand_vec();
    logic [WORD_W*NUM_WORDS-1:0] v;
    for (int k = 0; k < NUM_WORDS; k++) v[k*WORD_W +: WORD_W] = WORD_W'($urandom);
    return v;
  endfunction

  // Monitor: every write must match the head of the expected queue, done
  // may only appear in a cycle the model predicted, busy must follow the
  // predicted window.
  initial begin
    logic [EW-1:0] got;
    logic [EW-1:0] exp_w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("busy", 64'(busy), 64'((cyc >= bz_lo && cyc < bz_hi) ? 1 : 0));
        if (mem_write_enable) begin
          got = {32'(cyc), mem_address, mem_data};
          n_wr++;
          last_wr_addr = mem_address;
          mem_model[mem_address] = mem_data;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL write_unexpected: got %0h expected none", got);
          end else begin
            exp_w = exp_q.pop_front();
            check("write", 64'(got), 64'(exp_w));
          end
        end
        if (done) begin
          n_chk++;
          if (!exp_done_at.exists(cyc)) begin
            n_err++;
            $display("FAIL done_spurious: got done at cycle %0d expected none", cyc);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  // hmode: 0 no hold, 1 hold for edges hs..hs+hl-1 after accept, 2 random.
  // Returns with the bench #1 after the edge that raised done.
  task automatic run_burst(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c,
                           input int hmode, input int hs, input int hl,
                           input bit noise, input bit chained,
                           output int lat, output int nwr);
    int eff, t_acc, d_exp, j, w, n0;
    bit hp [HP_N];
    logic [WORD_W*NUM_WORDS-1:0] v;
    if (!chained) begin
      @(posedge clk);
      #1;
    end
    v   = stim_vec;
    eff = (int'(c) > NUM_WORDS) ? NUM_WORDS : int'(c);
    for (int k = 0; k < HP_N; k++) begin
      case (hmode)
        1:       hp[k] = (k >= hs) && (k < hs + hl);
        2:       hp[k] = ($urandom_range(0, 3) == 0);
        default: hp[k] = 1'b0;
      endcase
    end
    // Walk the edges after acceptance: each non-held edge writes the next
    // word; done follows the edge that wrote the last one.
    t_acc = cyc + 1;
    j = 0;
    w = 0;
    while (w < eff) begin
      if (!(j < HP_N && hp[j])) begin
        exp_q.push_back({32'(t_acc + 1 + j), ADDR_W'(int'(b) + w), v[w*WORD_W +: WORD_W]});
        w++;
      end
      j++;
    end
    d_exp = t_acc + 1 + j;
    exp_done_at[d_exp] = 1'b1;
    bz_lo = t_acc;
    bz_hi = d_exp;
    n0    = n_wr;

    start     = 1'b1;
    base_addr = b;
    count     = c;
    vec_in    = v;
    hold      = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = ~b;
    count     = CNT_W'($urandom);
    vec_in    = ~v;
    j = 0;
    while (!done && j < 1000) begin
      hold  = (j < HP_N) ? hp[j] : 1'b0;
      start = noise && (j == 1);
      if (start) begin
        base_addr = ADDR_W'($urandom);
        count     = CNT_W'($urandom_range(1, 127));
        vec_in    = rand_vec();
      end
      @(posedge clk);
      #1;
      j++;
    end
    start = 1'b0;
    hold  = 1'b0;
    lat   = cyc - t_acc;
    nwr   = n_wr - n0;
    check("latency", 64'(lat), 64'(d_exp - t_acc));
    check("done_pulse", 64'(done), 64'(1));
    check("busy_at_done", 64'(busy), 64'(0));
    check("we_at_done", 64'(mem_write_enable), 64'(0));
    check("writes_left", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  cnt;
    int                hmode;
    int                hs;
    int                hl;
    bit                inc;
    int                exp_wr;
    int                exp_lat;
    logic [ADDR_W-1:0] exp_last;
  } vec_t;

  vec_t tbl [7];
  int   lat, nwr, nwr_rst, eff, t_acc;
  logic [ADDR_W-1:0] rb;
  logic [CNT_W-1:0]  rc;

  initial begin
    tbl[0] = '{14'd0,     7'd120, 0, 0, 0, 1'b1, 120, 121, 14'd119};
    tbl[1] = '{14'd100,   7'd127, 0, 0, 0, 1'b0, 120, 121, 14'd219};
    tbl[2] = '{14'd5,     7'd0,   0, 0, 0, 1'b0, 0,   1,   14'd0};
    tbl[3] = '{14'd16380, 7'd6,   0, 0, 0, 1'b0, 6,   7,   14'd1};
    tbl[4] = '{14'd40,    7'd4,   1, 2, 3, 1'b0, 4,   8,   14'd43};
    tbl[5] = '{14'd16383, 7'd1,   0, 0, 0, 1'b0, 1,   2,   14'd16383};
    tbl[6] = '{14'd7,     7'd119, 0, 0, 0, 1'b0, 119, 120, 14'd125};

    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    vec_in    = '0;
    hold      = 1'b0;
    stim_vec  = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", 64'(mem_address), 64'(0));
    check("rst_data", 64'(mem_data), 64'(0));
    check("rst_we", 64'(mem_write_enable), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Table of directed bursts.
    for (int t = 0; t < 7; t++) begin
      if (tbl[t].inc) begin
        for (int k = 0; k < NUM_WORDS; k++) stim_vec[k*WORD_W +: WORD_W] = WORD_W'(k + 1);
      end else begin
        stim_vec = rand_vec();
      end
      run_burst(tbl[t].base, tbl[t].cnt, tbl[t].hmode, tbl[t].hs, tbl[t].hl, 1'b0, 1'b0, lat, nwr);
      check($sformatf("tbl%0d_writes", t), 64'(nwr), 64'(tbl[t].exp_wr));
      check($sformatf("tbl%0d_latency", t), 64'(lat), 64'(tbl[t].exp_lat));
      if (tbl[t].exp_wr > 0) begin
        check($sformatf("tbl%0d_last_addr", t), 64'(last_wr_addr), 64'(tbl[t].exp_last));
      end
      if (t == 0) begin
        for (int k = 0; k < NUM_WORDS; k++) begin
          check($sformatf("readback%0d", k), 64'(mem_model[k]), 64'(k + 1));
        end
      end
    end

    // start pulsed mid-burst with new operands is ignored.
    stim_vec = rand_vec();
    run_burst(14'd200, 7'd30, 0, 0, 0, 1'b1, 1'b0, lat, nwr);
    check("ignored_start_writes", 64'(nwr), 64'(30));
    check("ignored_start_latency", 64'(lat), 64'(31));

    // Back-to-back: second start raised in the done cycle.
    stim_vec = rand_vec();
    run_burst(14'd300, 7'd10, 0, 0, 0, 1'b0, 1'b0, lat, nwr);
    stim_vec = rand_vec();
    run_burst(14'd500, 7'd8, 0, 0, 0, 1'b0, 1'b1, lat, nwr);
    check("b2b_writes", 64'(nwr), 64'(8));
    check("b2b_latency", 64'(lat), 64'(9));
    check("b2b_last_addr", 64'(last_wr_addr), 64'(507));

    // Reset after 10 writes of a 40-word burst.
    @(posedge clk);
    #1;
    stim_vec = rand_vec();
    t_acc = cyc + 1;
    for (int w = 0; w < 10; w++) begin
      exp_q.push_back({32'(t_acc + 1 + w), ADDR_W'(1000 + w), stim_vec[w*WORD_W +: WORD_W]});
    end
    bz_lo     = t_acc;
    bz_hi     = t_acc + 100000;
    start     = 1'b1;
    base_addr = 14'd1000;
    count     = 7'd40;
    vec_in    = stim_vec;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    bz_hi = 0;
    nwr_rst = n_wr;
    check("midrst_writes_seen", 64'(exp_q.size()), 64'(0));
    check("midrst_addr", 64'(mem_address), 64'(0));
    check("midrst_data", 64'(mem_data), 64'(0));
    check("midrst_we", 64'(mem_write_enable), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("postrst_state", 64'(dbg_state), 64'(0));
    check("postrst_busy", 64'(busy), 64'(0));
    check("postrst_no_writes", 64'(n_wr - nwr_rst), 64'(0));
    stim_vec = rand_vec();
    run_burst(14'd16382, 7'd5, 0, 0, 0, 1'b0, 1'b0, lat, nwr);
    check("postrst_burst_writes", 64'(nwr), 64'(5));
    check("postrst_burst_last", 64'(last_wr_addr), 64'(2));

    // Randomized bursts against the model.
    for (int r = 0; r < 25; r++) begin
      stim_vec = rand_vec();
      rb = ADDR_W'($urandom);
      case ($urandom_range(0, 4))
        0:       rc = CNT_W'($urandom_range(118, 127));
        1:       rc = CNT_W'($urandom_range(0, 2));
        default: rc = CNT_W'($urandom_range(0, 127));
      endcase
      eff = (int'(rc) > NUM_WORDS) ? NUM_WORDS : int'(rc);
      run_burst(rb, rc, int'($urandom_range(0, 2)), int'($urandom_range(0, 10)),
                int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0), lat, nwr);
      check($sformatf("rand%0d_writes", r), 64'(nwr), 64'(eff));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule
